pipe_stage_hs: RTL and testbench
================================

// Module: pipe_stage_hs
// PURPOSE
//  Parametrised pipeline stage register, successor to the fixed-field stall/clear stage registers.
//  Carries an opaque WIDTH-bit payload (packed control+data bundle) between two pipeline stages.
//  Uses a valid/ready handshake; SKID=1 adds a second entry so in_ready is registered.
//  flush inserts a bubble whose payload equals RESET_VAL, e.g. MDUOp = MDU_DUM.
// PARAMETERS
//  WIDTH      32             payload width in bits (>=1)
//  RESET_VAL  {WIDTH{1'b0}}  payload value driven on out_data after reset/flush/drain (bubble encoding)
//  SKID       1              1: two-entry skid buffer, in_ready registered; 0: single entry, in_ready combinational
// PORTS
//  clk        in   1      rising-edge clock, only clock
//  reset      in   1      synchronous, active-high reset
//  flush      in   1      synchronous bubble insert: discard all held entries
//  in_valid   in   1      upstream has payload on in_data
//  in_ready   out  1      stage accepts in_data this cycle
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      out_data holds a valid payload
//  out_ready  in   1      downstream accepts out_data this cycle
//  out_data   out  WIDTH  payload to downstream
//  occupancy  out  2      number of held entries (0..2; max 1 when SKID=0)
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (reset). All state updates on posedge clk.
//  - Transfers: input when in_valid&in_ready; output when out_valid&out_ready, both sampled at posedge.
//  - Priority per edge: reset > flush > normal operation.
//  - After reset edge: state EMPTY; out_valid=0; out_data=RESET_VAL; occupancy=0.
//    in_ready=1 unless flush is high; skid entry=RESET_VAL.
//  - States: EMPTY (occ 0), FULL (occ 1, main valid), SKID (occ 2, main+skid valid; SKID=1 only).
//  - EMPTY: input xfer -> FULL, main<=in_data. Otherwise stay; main holds RESET_VAL.
//  - FULL:
//      out xfer, no in xfer   -> EMPTY, main<=RESET_VAL
//      out xfer + in xfer     -> FULL, main<=in_data (full throughput, 1 item/cycle)
//      no out xfer, in xfer   -> SKID, skid<=in_data (SKID=1)
//      neither                -> hold
//  - SKID: in_ready=0. out xfer -> FULL, main<=skid, skid<=RESET_VAL; else hold.
//  - out_valid = (state!=EMPTY); out_data = main register; occupancy = state encoding.
//  - in_ready:
//      SKID=1: registered (state!=SKID), gated by !flush.
//      SKID=0: (!out_valid | out_ready) & !flush; in FULL an input xfer requires a same-cycle out xfer.
//  - flush=1: in_ready forced 0 combinationally, so no upstream handshake is lost.
//    An out xfer in the flush cycle counts as completed (downstream consumed it).
//    Next state EMPTY, main=skid=RESET_VAL, occupancy=0.
//  - Latency: in xfer at edge N -> out_valid=1 after edge N; zero-bubble back-to-back when out_ready=1.
//  - out_data stable while out_valid&!out_ready (no change until consumed or flushed).
//  - Reset or flush mid-SKID discards both entries; no partial payload is ever emitted.
// TESTING
//  1 Reset: hold reset 2 cycles with in_valid=1, in_data=0xAAAA_AAAA.
//    -> out_valid=0, out_data=RESET_VAL, occupancy=0, in_ready=1 after release.
//  2 Streaming, out_ready=1: push 0x1,0x2,0x3 on consecutive cycles.
//    -> emerges 0x1,0x2,0x3 on consecutive cycles, 1 cycle after each accept; in_ready stays 1.
//  3 Backpressure, SKID=1: push 0x10,0x11,0x12 with out_ready=0.
//    -> 0x10,0x11 accepted; occupancy=2; in_ready=0; 0x12 held upstream.
//    Raise out_ready -> 0x10,0x11,0x12 delivered in order, none lost or duplicated.
//  4 Flush in SKID state (main=0x20, skid=0x21), out_ready=0.
//    -> next cycle out_valid=0, out_data=RESET_VAL, occupancy=0; 0x20/0x21 never emitted; in_ready=0 during flush.
//  5 Flush coincident with out xfer and in_valid: out 0x30 consumed, in 0x31 not accepted (in_ready=0).
//    -> EMPTY next cycle; 0x31 accepted on the following cycle.
//  6 SKID=0, FULL, out_ready=0: in_ready=0.
//    Set out_ready=1 with in_valid (0x40) -> same-cycle swap, out_data=0x40 next cycle.
//    Random valid/ready scoreboard: 10k cycles, in-order, no loss.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: parametrised pipeline stage register with a valid/ready handshake.
// Moves an opaque WIDTH-bit payload (a packed control+data bundle) from one
// pipeline stage to the next.
//
// SKID=1 adds a second entry. This lets in_ready come straight from a flop
// instead of depending on out_ready in the same cycle.
//
// A flush discards every held entry. The stage then presents a bubble whose
// payload is RESET_VAL.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   flush      synchronous bubble insert, discards all held entries
//   in_valid   upstream has a payload on in_data
//   in_ready   stage accepts in_data this cycle
//   in_data    upstream payload (WIDTH bits)
//   out_valid  out_data holds a valid payload
//   out_ready  downstream accepts out_data this cycle
//   out_data   payload to downstream (WIDTH bits), RESET_VAL when empty
//   occupancy  number of held entries (0..2, max 1 when SKID=0)
module pipe_stage_hs #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // The encoding equals the entry count, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    SKIDFULL = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mainData;
  logic [WIDTH-1:0] skidData;
  logic             readyReg;
  logic             inXfer;
  logic             outXfer;

  assign out_valid = (state != EMPTY);
  assign out_data  = mainData;
  assign occupancy = state;

  // Skid variant: in_ready comes from a flop (low only while both entries are held).
  // Single-entry variant: a full stage may accept only when it drains in the same cycle.
  // A flush always blocks acceptance, so no upstream handshake is lost.
  assign in_ready = !flush & (SKID ? readyReg : (!out_valid | out_ready));

  assign inXfer  = in_valid & in_ready;
  assign outXfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      // A transfer out in a flush cycle has already been consumed downstream;
      // nothing else needs to be kept.
      state    <= EMPTY;
      mainData <= RESET_VAL;
      skidData <= RESET_VAL;
      readyReg <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (inXfer) begin
            state    <= FULL;
            mainData <= in_data;
          end
        end
        FULL: begin
          if (outXfer && inXfer) begin
            mainData <= in_data;
          end else if (outXfer) begin
            state    <= EMPTY;
            mainData <= RESET_VAL;
          end else if (inXfer && SKID) begin
            // Downstream stalled while upstream delivered: park the payload in the skid entry.
            state    <= SKIDFULL;
            skidData <= in_data;
            readyReg <= 1'b0;
          end
        end
        SKIDFULL: begin
          if (outXfer) begin
            state    <= FULL;
            mainData <= skidData;
            skidData <= RESET_VAL;
            readyReg <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          mainData <= RESET_VAL;
          skidData <= RESET_VAL;
          readyReg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
module tb_pipe_stage_hs;

  localparam logic [31:0] R1 = 32'hDEAD_BEEF;
  localparam logic [31:0] R0 = 32'h0BAD_0000;

  logic        clk = 1'b0;
  logic        rst1, fl1, iv1, ir1, ov1, ordy1;
  logic [31:0] d1, od1;
  logic [1:0]  occ1;
  logic        rst0, fl0, iv0, ir0, ov0, ordy0;
  logic [31:0] d0, od0;
  logic [1:0]  occ0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_hs #(.WIDTH(32), .RESET_VAL(R1), .SKID(1'b1)) dutSkid (
    .clk(clk), .reset(rst1), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
    .in_data(d1), .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .occupancy(occ1)
  );

  pipe_stage_hs #(.WIDTH(32), .RESET_VAL(R0), .SKID(1'b0)) dutNoSkid (
    .clk(clk), .reset(rst0), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
    .in_data(d0), .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .occupancy(occ0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One record per cycle. Inputs are applied after a falling edge; the expected
  // outputs describe that same cycle, just before the next rising edge.
  typedef struct {
    logic        rst, fl, iv;
    logic [31:0] id;
    logic        ordy, en, eov;
    logic [31:0] eod;
    logic [1:0]  eocc;
    logic        eir;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t V(logic rst, logic fl, logic iv, logic [31:0] id, logic ordy,
                             logic en, logic eov, logic [31:0] eod, logic [1:0] eocc, logic eir);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.en = en; v.eov = eov; v.eod = eod; v.eocc = eocc; v.eir = eir;
    return v;
  endfunction

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic        acc1, acc0;

  initial begin
    rst1 = 1'b1; fl1 = 1'b0; iv1 = 1'b0; d1 = '0; ordy1 = 1'b0;
    rst0 = 1'b1; fl0 = 1'b0; iv0 = 1'b0; d0 = '0; ordy0 = 1'b0;
    acc1 = 1'b0; acc0 = 1'b0;

    //            rst fl iv id            ordy en ov od            occ ir
    // reset held two cycles with a payload offered
    tbl[0]  = V(1, 0, 1, 32'hAAAA_AAAA, 0,  0, 0, R1,           0, 1);
    tbl[1]  = V(1, 0, 1, 32'hAAAA_AAAA, 0,  1, 0, R1,           0, 1);
    tbl[2]  = V(0, 0, 0, 32'h0,         0,  1, 0, R1,           0, 1);
    // streaming, one item per cycle
    tbl[3]  = V(0, 0, 1, 32'h1,         1,  1, 0, R1,           0, 1);
    tbl[4]  = V(0, 0, 1, 32'h2,         1,  1, 1, 32'h1,        1, 1);
    tbl[5]  = V(0, 0, 1, 32'h3,         1,  1, 1, 32'h2,        1, 1);
    tbl[6]  = V(0, 0, 0, 32'h0,         1,  1, 1, 32'h3,        1, 1);
    tbl[7]  = V(0, 0, 0, 32'h0,         0,  1, 0, R1,           0, 1);
    // backpressure fills the skid entry; 0x12 waits upstream
    tbl[8]  = V(0, 0, 1, 32'h10,        0,  1, 0, R1,           0, 1);
    tbl[9]  = V(0, 0, 1, 32'h11,        0,  1, 1, 32'h10,       1, 1);
    tbl[10] = V(0, 0, 1, 32'h12,        0,  1, 1, 32'h10,       2, 0);
    tbl[11] = V(0, 0, 1, 32'h12,        1,  1, 1, 32'h10,       2, 0);
    tbl[12] = V(0, 0, 1, 32'h12,        1,  1, 1, 32'h11,       1, 1);
    tbl[13] = V(0, 0, 0, 32'h0,         1,  1, 1, 32'h12,       1, 1);
    tbl[14] = V(0, 0, 0, 32'h0,         0,  1, 0, R1,           0, 1);
    // flush while both entries are held
    tbl[15] = V(0, 0, 1, 32'h20,        0,  1, 0, R1,           0, 1);
    tbl[16] = V(0, 0, 1, 32'h21,        0,  1, 1, 32'h20,       1, 1);
    tbl[17] = V(0, 1, 0, 32'h0,         0,  1, 1, 32'h20,       2, 0);
    tbl[18] = V(0, 0, 0, 32'h0,         0,  1, 0, R1,           0, 1);
    // flush coinciding with an output transfer and an offered input
    tbl[19] = V(0, 0, 1, 32'h30,        0,  1, 0, R1,           0, 1);
    tbl[20] = V(0, 1, 1, 32'h31,        1,  1, 1, 32'h30,       1, 0);
    tbl[21] = V(0, 0, 1, 32'h31,        0,  1, 0, R1,           0, 1);
    tbl[22] = V(0, 0, 0, 32'h0,         1,  1, 1, 32'h31,       1, 1);
    tbl[23] = V(0, 0, 0, 32'h0,         0,  1, 0, R1,           0, 1);
    // reset while both entries are held
    tbl[24] = V(0, 0, 1, 32'h50,        0,  1, 0, R1,           0, 1);
    tbl[25] = V(0, 0, 1, 32'h51,        0,  1, 1, 32'h50,       1, 1);
    tbl[26] = V(1, 0, 1, 32'h52,        1,  1, 1, 32'h50,       2, 0);
    tbl[27] = V(0, 0, 0, 32'h0,         1,  1, 0, R1,           0, 1);

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      rst1 = tbl[i].rst; fl1 = tbl[i].fl; iv1 = tbl[i].iv; d1 = tbl[i].id; ordy1 = tbl[i].ordy;
      rst0 = (i < 2);
      #1;
      if (tbl[i].en) begin
        chk($sformatf("vec%0d out_valid", i), 32'(ov1), 32'(tbl[i].eov));
        chk($sformatf("vec%0d out_data", i), od1, tbl[i].eod);
        chk($sformatf("vec%0d occupancy", i), 32'(occ1), 32'(tbl[i].eocc));
        chk($sformatf("vec%0d in_ready", i), 32'(ir1), 32'(tbl[i].eir));
      end
    end

    // Single-entry variant: a full stage blocks input until downstream drains it,
    // then swaps old for new in one cycle.
    @(negedge clk); rst0 = 1'b0; iv0 = 1'b1; d0 = 32'h3F; ordy0 = 1'b0; #1;
    chk("s0 empty out_valid", 32'(ov0), 32'd0);
    chk("s0 empty out_data", od0, R0);
    chk("s0 empty in_ready", 32'(ir0), 32'd1);
    @(negedge clk); iv0 = 1'b1; d0 = 32'h40; ordy0 = 1'b0; #1;
    chk("s0 full stalled in_ready", 32'(ir0), 32'd0);
    chk("s0 full out_data", od0, 32'h3F);
    chk("s0 full occupancy", 32'(occ0), 32'd1);
    @(negedge clk); ordy0 = 1'b1; #1;
    chk("s0 swap in_ready", 32'(ir0), 32'd1);
    chk("s0 swap out_data", od0, 32'h3F);
    @(negedge clk); iv0 = 1'b0; ordy0 = 1'b0; #1;
    chk("s0 after swap out_data", od0, 32'h40);
    chk("s0 after swap out_valid", 32'(ov0), 32'd1);
    @(negedge clk); ordy0 = 1'b1; #1;
    @(negedge clk); ordy0 = 1'b0; #1;
    chk("s0 drained out_valid", 32'(ov0), 32'd0);
    chk("s0 drained out_data", od0, R0);

    // Random valid/ready on both variants. An offered payload is held until accepted.
    // The final cycles stop offering input and keep out_ready high to drain.
    iv1 = 1'b0; iv0 = 1'b0;
    for (int cyc = 0; cyc < 10060; cyc++) begin
      @(negedge clk);
      if (cyc >= 10000) begin
        iv1 = 1'b0; iv0 = 1'b0; ordy1 = 1'b1; ordy0 = 1'b1;
      end else begin
        if (!(iv1 && !acc1)) begin iv1 = 1'($urandom_range(0, 1)); d1 = $urandom; end
        if (!(iv0 && !acc0)) begin iv0 = 1'($urandom_range(0, 1)); d0 = $urandom; end
        ordy1 = ($urandom_range(0, 3) != 0);
        ordy0 = ($urandom_range(0, 1) != 0);
      end
      #1;
      chk("rnd s1 occupancy", 32'(occ1), 32'(q1.size()));
      chk("rnd s0 occupancy", 32'(occ0), 32'(q0.size()));
      chk("rnd s0 in_ready", 32'(ir0), 32'((occ0 == 2'd0) | ordy0));
      if (ov1 && ordy1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd s1 spurious output: got %h expected none", od1);
        end else chk("rnd s1 data", od1, q1.pop_front());
      end
      if (ov0 && ordy0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd s0 spurious output: got %h expected none", od0);
        end else chk("rnd s0 data", od0, q0.pop_front());
      end
      acc1 = iv1 && ir1;
      acc0 = iv0 && ir0;
      if (acc1) q1.push_back(d1);
      if (acc0) q0.push_back(d0);
    end
    chk("drain s1 leftover", 32'(q1.size()), 32'd0);
    chk("drain s0 leftover", 32'(q0.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
